// File: rtl/fft8_frame_host.sv
// -----------------------------------------------------------------------------
// fft8_frame_host
// Host-side bridge for the fft8 core. It collects eight serial samples into a
// parallel frame, launches the frame with a one-cycle fft_valid pulse, and waits
// for the core's fft_result_valid. It then captures all sixteen result words
// and streams them out one bin per cycle under valid/ready.
// Only one frame is in flight at a time, because the core cannot apply
// backpressure.
//
// Optional feature: define FFT8_HOST_TIMEOUT_EN to abort a frame when the core
// has not answered within TIMEOUT_CYCLES WAIT cycles. Without the macro the
// block waits forever and timeout_err is held at 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data/in_valid/in_ready   serial sample input (in_ready = state==COLLECT)
//   fft_x, fft_valid    parallel frame and launch strobe to the core
//   fft_y, fft_y_i, fft_result_valid   core results (slot k at [k*W +: W])
//   out_re/out_im/out_idx/out_last/out_valid/out_ready   bin output stream
//   frame_count         completed frames, 16-bit wrapping
//   spurious_err        sticky: result strobe seen outside WAIT
//   timeout_err         sticky: WAIT aborted by the timeout
// -----------------------------------------------------------------------------
module fft8_frame_host #(
    parameter int INT_SIZE       = 8,
    parameter int FRAC_SIZE      = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [INT_SIZE+FRAC_SIZE-1:0]       in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [8*(INT_SIZE+FRAC_SIZE)-1:0]   fft_x,
    output logic                                fft_valid,
    input  logic [8*(INT_SIZE+FRAC_SIZE)-1:0]   fft_y,
    input  logic [8*(INT_SIZE+FRAC_SIZE)-1:0]   fft_y_i,
    input  logic                                fft_result_valid,
    output logic [INT_SIZE+FRAC_SIZE-1:0]       out_re,
    output logic [INT_SIZE+FRAC_SIZE-1:0]       out_im,
    output logic [2:0]                          out_idx,
    output logic                                out_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [15:0]                         frame_count,
    output logic                                spurious_err,
    output logic                                timeout_err
);

    localparam int W = INT_SIZE + FRAC_SIZE;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_wr_idx;
    logic [2:0]       r_rd_idx;
    logic [2:0]       w_rd_next;
    logic [8*W-1:0]   r_fft_x;
    logic             r_fft_valid;
    logic [W-1:0]     r_buf_re [0:7];
    logic [W-1:0]     r_buf_im [0:7];
    logic [W-1:0]     r_out_re;
    logic [W-1:0]     r_out_im;
    logic [2:0]       r_out_idx;
    logic             r_out_last;
    logic             r_out_valid;
    logic [15:0]      r_frame_count;
    logic             r_spurious_err;
    logic             w_timeout;

    assign w_rd_next = r_rd_idx + 3'd1;

`ifdef FFT8_HOST_TIMEOUT_EN
    localparam int              TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;

    // The counter shows how many WAIT cycles have already passed. The
    // TIMEOUT_CYCLES-th cycle aborts unless a result arrives in the same cycle.
    assign w_timeout = (r_state == WAIT) && !fft_result_valid && (r_to_cnt == TO_MAX);

    // Timeout counter (cleared while launching) and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == LAUNCH) begin
                r_to_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            COLLECT: begin
                if (in_valid && (r_wr_idx == 3'd7)) begin
                    w_next_state = LAUNCH;
                end else begin
                    w_next_state = COLLECT;
                end
            end
            LAUNCH: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                if (fft_result_valid) begin
                    w_next_state = DRAIN;
                end else if (w_timeout) begin
                    w_next_state = COLLECT;
                end else begin
                    w_next_state = WAIT;
                end
            end
            DRAIN: begin
                if (out_ready && (r_rd_idx == 3'd7)) begin
                    w_next_state = COLLECT;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            default: begin
                w_next_state = COLLECT;
            end
        endcase
    end

    // Datapath: sample collection, launch strobe, result capture and bin streaming.
    // fft_valid is set on the edge that enters LAUNCH. That keeps it high for
    // exactly the LAUNCH cycle and still comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx       <= 3'd0;
            r_rd_idx       <= 3'd0;
            r_fft_x        <= '0;
            r_fft_valid    <= 1'b0;
            r_out_re       <= '0;
            r_out_im       <= '0;
            r_out_idx      <= 3'd0;
            r_out_last     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_frame_count  <= 16'd0;
            r_spurious_err <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_buf_re[k] <= '0;
                r_buf_im[k] <= '0;
            end
        end else begin
            if (fft_result_valid && (r_state != WAIT)) begin
                r_spurious_err <= 1'b1;
            end
            case (r_state)
                COLLECT: begin
                    if (in_valid) begin
                        r_fft_x[int'(r_wr_idx)*W +: W] <= in_data;
                        r_wr_idx                      <= r_wr_idx + 3'd1;
                        r_fft_valid                   <= (r_wr_idx == 3'd7);
                    end
                end
                LAUNCH: begin
                    r_fft_valid <= 1'b0;
                end
                WAIT: begin
                    if (fft_result_valid) begin
                        for (int k = 0; k < 8; k++) begin
                            r_buf_re[k] <= fft_y[k*W +: W];
                            r_buf_im[k] <= fft_y_i[k*W +: W];
                        end
                        // Bin 0 is presented directly from the core bus, because
                        // the buffer is only written on this same edge.
                        r_out_re    <= fft_y[0 +: W];
                        r_out_im    <= fft_y_i[0 +: W];
                        r_out_idx   <= 3'd0;
                        r_out_last  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_rd_idx    <= 3'd0;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (r_rd_idx == 3'd7) begin
                            r_out_valid   <= 1'b0;
                            r_out_last    <= 1'b0;
                            r_rd_idx      <= 3'd0;
                            r_frame_count <= r_frame_count + 16'd1;
                        end else begin
                            r_rd_idx   <= w_rd_next;
                            r_out_re   <= r_buf_re[w_rd_next];
                            r_out_im   <= r_buf_im[w_rd_next];
                            r_out_idx  <= w_rd_next;
                            r_out_last <= (w_rd_next == 3'd7);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready     = (r_state == COLLECT);
    assign fft_x        = r_fft_x;
    assign fft_valid    = r_fft_valid;
    assign out_re       = r_out_re;
    assign out_im       = r_out_im;
    assign out_idx      = r_out_idx;
    assign out_last     = r_out_last;
    assign out_valid    = r_out_valid;
    assign frame_count  = r_frame_count;
    assign spurious_err = r_spurious_err;

endmodule

// File: tb/tb_fft8_frame_host.sv
// -----------------------------------------------------------------------------
// tb_fft8_frame_host
// Directed bench for fft8_frame_host. A small core stub answers 4 cycles after
// fft_valid with y = x and y_i = ~x. Expected bins are queued when samples are
// sent, then popped and compared as the DUT streams them out.
// -----------------------------------------------------------------------------
module tb_fft8_frame_host;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [2:0]   idx;
    } bin_t;

    logic           clk;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [8*W-1:0] fft_x;
    logic           fft_valid;
    logic [8*W-1:0] fft_y;
    logic [8*W-1:0] fft_y_i;
    logic           fft_result_valid;
    logic [W-1:0]   out_re;
    logic [W-1:0]   out_im;
    logic [2:0]     out_idx;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;
    logic [15:0]    frame_count;
    logic           spurious_err;
    logic           timeout_err;

    logic           stub_en;
    logic           force_rv;
    logic [3:0]     v_pipe = 4'd0;
    logic [8*W-1:0] stub_x = '0;

    bin_t           sb[$];
    int             n_total = 0;
    int             n_bad   = 0;
    logic [15:0]    exp_fc  = 16'd0;

    fft8_frame_host #(.INT_SIZE(8), .FRAC_SIZE(8), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .fft_x(fft_x), .fft_valid(fft_valid),
        .fft_y(fft_y), .fft_y_i(fft_y_i), .fft_result_valid(fft_result_valid),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .frame_count(frame_count), .spurious_err(spurious_err), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: 4-cycle latency, echoes the launched frame
    always @(posedge clk) begin
        v_pipe <= {v_pipe[2:0], fft_valid};
        if (fft_valid) stub_x <= fft_x;
    end

    assign fft_result_valid = (stub_en & v_pipe[3]) | force_rv;
    assign fft_y   = force_rv ? {(8*W){1'b1}} : stub_x;
    assign fft_y_i = force_rv ? {(8*W){1'b1}} : ~stub_x;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_fft_x", fft_x, 128'd0);
        check("rst_fft_valid", fft_valid, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_re", out_re, 16'd0);
        check("rst_out_im", out_im, 16'd0);
        check("rst_out_idx", out_idx, 3'd0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_frame_count", frame_count, 16'd0);
        check("rst_spurious", spurious_err, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
    endtask

    // Sends 8 samples base..base+7 (optionally with idle gaps), queues the
    // expected bins and checks the one-cycle launch strobe and frame contents.
    task automatic send_frame(input logic [15:0] base, input bit gaps);
        int k = 0;
        int guard = 0;
        bit acc;
        bin_t e;
        logic [8*W-1:0] ex = '0;
        while (k < 8 && guard < 100) begin
            acc = 1'b0;
            in_data = base + 16'(k);
            if (gaps && (guard % 2 == 1)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                acc = in_ready;
            end
            @(negedge clk);
            if (acc) begin
                ex[k*W +: W] = base + 16'(k);
                e.re  = base + 16'(k);
                e.im  = ~(base + 16'(k));
                e.idx = 3'(k);
                sb.push_back(e);
                k++;
            end
            guard++;
        end
        in_valid = 1'b0;
        check("samples_accepted", k, 8);
        check("launch_fft_valid", fft_valid, 1'b1);
        check("launch_fft_x", fft_x, ex);
        check("launch_in_ready", in_ready, 1'b0);
        @(negedge clk);
        check("post_launch_fft_valid", fft_valid, 1'b0);
        check("post_launch_fft_x_held", fft_x, ex);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_rise", out_valid, 1'b1);
    endtask

    // Drains nbins bins; mode 0 = ready always high, mode 1 = ready 1,0,0,1 pattern
    task automatic drain(input int mode, input int nbins);
        int got = 0;
        int c = 0;
        bin_t e;
        while (got < nbins && c < 200) begin
            out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            if (out_valid) begin
                check("in_ready_drain", in_ready, 1'b0);
                if (sb.size() == 0) begin
                    check("sb_underflow", 1'b1, 1'b0);
                end else begin
                    e = sb[0];
                    check("out_re", out_re, e.re);
                    check("out_im", out_im, e.im);
                    check("out_idx", out_idx, e.idx);
                    check("out_last", out_last, (e.idx == 3'd7));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        got++;
                    end
                end
            end
            @(negedge clk);
            c++;
        end
        out_ready = 1'b0;
        check("drain_bins", got, nbins);
    endtask

    task automatic finish_frame(input int mode);
        int lat;
        wait_out(lat);
        drain(mode, 8);
        exp_fc = exp_fc + 16'd1;
        check("post_drain_out_valid", out_valid, 1'b0);
        check("post_drain_in_ready", in_ready, 1'b1);
        check("frame_count", frame_count, exp_fc);
    endtask

    initial begin
        int lat;
        int cyc;
        rst = 1'b1; in_data = 16'd0; in_valid = 1'b0; out_ready = 1'b0;
        stub_en = 1'b1; force_rv = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset();

        // 1: basic frame, latency and contents
        send_frame(16'h0101, 1'b0);
        wait_out(lat);
        check("latency_from_launch", lat, 5);
        drain(0, 8);
        exp_fc = exp_fc + 16'd1;
        check("frame_count_1", frame_count, exp_fc);
        check("in_ready_after_1", in_ready, 1'b1);

        // 2: same frame with stalls on the output side
        send_frame(16'h0101, 1'b0);
        finish_frame(1);
        check("no_spurious_yet", spurious_err, 1'b0);

        // 3: spurious result during COLLECT, then a normal gapped frame
        force_rv = 1'b1;
        @(negedge clk);
        force_rv = 1'b0;
        @(negedge clk);
        check("spurious_set", spurious_err, 1'b1);
        send_frame(16'h0201, 1'b1);
        finish_frame(0);
        check("spurious_sticky", spurious_err, 1'b1);

        // 4: reset in the middle of DRAIN, at bin 3
        send_frame(16'h0301, 1'b0);
        wait_out(lat);
        drain(0, 3);
        check("pre_reset_idx", out_idx, 3'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_fc = 16'd0;
        check_reset();
        send_frame(16'h0401, 1'b0);
        finish_frame(0);

        // 5: frame counter wrap
        force dut.r_frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_count;
        exp_fc = 16'hFFFF;
        send_frame(16'h0501, 1'b0);
        finish_frame(0);
        check("frame_count_wrapped", frame_count, 16'h0000);

        // 6: core never answers
        stub_en = 1'b0;
        send_frame(16'h0601, 1'b0);
`ifdef FFT8_HOST_TIMEOUT_EN
        cyc = 1;
        while (!timeout_err && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_err_set", timeout_err, 1'b1);
        check("timeout_cycles", cyc, 16);
        check("timeout_in_ready", in_ready, 1'b1);
        check("timeout_out_valid", out_valid, 1'b0);
        check("timeout_frame_count", frame_count, exp_fc);
        sb.delete();
`else
        cyc = 0;
        repeat (40) begin
            @(negedge clk);
            cyc++;
        end
        check("stuck_in_ready", in_ready, 1'b0);
        check("stuck_out_valid", out_valid, 1'b0);
        check("stuck_timeout_err", timeout_err, 1'b0);
        check("stuck_frame_count", frame_count, exp_fc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_fc = 16'd0;
        check_reset();
`endif
        repeat (6) @(negedge clk);
        stub_en = 1'b1;
        send_frame(16'h0701, 1'b0);
        finish_frame(0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
